painel_de_senha: RTL and testbench

- Password-entry panel that drives the main access machine's "password accepted" input.
- Enabled by the main machine's password-panel status output.
- Collects keypad digits, compares them against the configured password, and reports accept or reject.
- Enforces a lockout after repeated wrong attempts.
- SENHA_OK connects directly to the main machine's STATUS_DA_SENHA_INSERIDA input.

---
 rtl/painel_de_senha_pkg.sv | 16 +
 rtl/painel_de_senha_if.sv | 24 ++
 rtl/painel_de_senha_temporizador_bloqueio.sv | 27 ++
 rtl/painel_de_senha.sv | 102 ++++++++++
 tb/tb_painel_de_senha.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/painel_de_senha_pkg.sv
// rtl/painel_de_senha_pkg.sv - shared state encoding and keypad constants for the password panel
package painel_de_senha_pkg;

   typedef enum logic [2:0] {
      OCIOSO      = 3'd0,
      COLETANDO   = 3'd1,
      VERIFICANDO = 3'd2,
      ACEITA      = 3'd3,
      REJEITA     = 3'd4,
      BLOQUEIO    = 3'd5
   } estado_t;

   localparam int DIGITO_W = 4;
   localparam logic [DIGITO_W-1:0] DIGITO_MAX = 4'd9;

endpackage

// File: rtl/painel_de_senha_if.sv
// rtl/painel_de_senha_if.sv - keypad and status signals between the panel and its driver
import painel_de_senha_pkg::*;

interface painel_de_senha_if;
   logic                HABILITA;
   logic [DIGITO_W-1:0] DIGITO;
   logic                DIGITO_VALIDO;
   logic                CONFIRMA;
   logic                LIMPA;
   logic                SENHA_OK;
   logic                SENHA_ERRADA;
   logic                BLOQUEADO;
   logic [3:0]          QTD_DIGITOS;

   modport master (
      output HABILITA, DIGITO, DIGITO_VALIDO, CONFIRMA, LIMPA,
      input  SENHA_OK, SENHA_ERRADA, BLOQUEADO, QTD_DIGITOS
   );

   modport slave (
      input  HABILITA, DIGITO, DIGITO_VALIDO, CONFIRMA, LIMPA,
      output SENHA_OK, SENHA_ERRADA, BLOQUEADO, QTD_DIGITOS
   );
endinterface

// File: rtl/painel_de_senha_temporizador_bloqueio.sv
// rtl/painel_de_senha_temporizador_bloqueio.sv - cycle timer; counts while start is held, done at terminal count
module temporizador_bloqueio #(
   parameter int CICLOS_BLOQUEIO = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic done
);
   localparam int W = $clog2(CICLOS_BLOQUEIO);
   localparam logic [W-1:0] TERMINAL = W'(CICLOS_BLOQUEIO - 1);

   logic [W-1:0] cnt;

   // start is a level: dropping it rearms the count from zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!start) begin
         cnt <= '0;
      end else if (cnt != TERMINAL) begin
         cnt <= cnt + W'(1);
      end
   end

   assign done = start && (cnt == TERMINAL);
endmodule

// File: rtl/painel_de_senha.sv
// rtl/painel_de_senha.sv - password entry panel with attempt counting and timed lockout
import painel_de_senha_pkg::*;

module painel_de_senha #(
   parameter int                       N_DIGITOS       = 4,
   parameter logic [4*N_DIGITOS-1:0]   SENHA_PADRAO    = 16'h1234,
   parameter int                       MAX_TENTATIVAS  = 3,
   parameter int                       CICLOS_BLOQUEIO = 1000
) (
   input  logic               clk,
   input  logic               rst_n,
   painel_de_senha_if.slave   bus
);
   localparam int BUF_W  = DIGITO_W * N_DIGITOS;
   localparam int TENT_W = $clog2(MAX_TENTATIVAS + 1);
   localparam logic [3:0]        N_CNT = 4'(N_DIGITOS);
   localparam logic [TENT_W-1:0] T_MAX = TENT_W'(MAX_TENTATIVAS);

   estado_t             state, state_n;
   logic [BUF_W-1:0]    buffer, buf_n;
   logic [3:0]          cnt, cnt_n;
   logic [TENT_W-1:0]   tent, tent_n;
   logic                fim_bloqueio;

   temporizador_bloqueio #(.CICLOS_BLOQUEIO(CICLOS_BLOQUEIO)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .start (state == BLOQUEIO),
      .done  (fim_bloqueio)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= OCIOSO;
         buffer <= '0;
         cnt    <= '0;
         tent   <= '0;
      end else begin
         state  <= state_n;
         buffer <= buf_n;
         cnt    <= cnt_n;
         tent   <= tent_n;
      end
   end

   always_comb begin
      state_n = state;
      buf_n   = buffer;
      cnt_n   = cnt;
      tent_n  = tent;
      case (state)
         OCIOSO: begin
            if (bus.HABILITA) begin
               state_n = COLETANDO;
               buf_n   = '0;
               cnt_n   = '0;
            end
         end
         COLETANDO: begin
            if (!bus.HABILITA) begin
               state_n = OCIOSO;
               buf_n   = '0;
               cnt_n   = '0;
            end else if (bus.LIMPA) begin
               buf_n = '0;
               cnt_n = '0;
            end else if (bus.CONFIRMA) begin
               state_n = VERIFICANDO;
            end else if (bus.DIGITO_VALIDO && bus.DIGITO <= DIGITO_MAX && cnt < N_CNT) begin
               buf_n = (buffer << DIGITO_W) | BUF_W'(bus.DIGITO);
               cnt_n = cnt + 4'd1;
            end
         end
         VERIFICANDO: begin
            // a short entry never matches, so it is counted as a wrong attempt
            state_n = (cnt == N_CNT && buffer == SENHA_PADRAO) ? ACEITA : REJEITA;
            buf_n   = '0;
            cnt_n   = '0;
         end
         ACEITA: begin
            tent_n = '0;
            if (!bus.HABILITA) state_n = OCIOSO;
         end
         REJEITA: begin
            tent_n  = tent + TENT_W'(1);
            state_n = (tent_n == T_MAX) ? BLOQUEIO : COLETANDO;
         end
         BLOQUEIO: begin
            if (fim_bloqueio) begin
               tent_n  = '0;
               state_n = bus.HABILITA ? COLETANDO : OCIOSO;
            end
         end
         default: state_n = OCIOSO;
      endcase
   end

   assign bus.SENHA_OK     = (state == ACEITA);
   assign bus.SENHA_ERRADA = (state == REJEITA);
   assign bus.BLOQUEADO    = (state == BLOQUEIO);
   assign bus.QTD_DIGITOS  = (state == COLETANDO) ? cnt : 4'd0;
endmodule

// File: tb/tb_painel_de_senha.sv
// tb/tb_painel_de_senha.sv - directed self-checking bench for painel_de_senha
module tb_painel_de_senha;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   int   lock_cycles;

   painel_de_senha_if bus();

   painel_de_senha dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] d);
      bus.DIGITO        = d;
      bus.DIGITO_VALIDO = 1'b1;
      step();
      bus.DIGITO_VALIDO = 1'b0;
   endtask

   task automatic confirm();
      bus.CONFIRMA = 1'b1;
      step();
      bus.CONFIRMA = 1'b0;
   endtask

   task automatic enter_1234();
      press(4'd1); press(4'd2); press(4'd3); press(4'd4);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      bus.HABILITA      = 1'b0;
      bus.DIGITO        = 4'd0;
      bus.DIGITO_VALIDO = 1'b0;
      bus.CONFIRMA      = 1'b0;
      bus.LIMPA         = 1'b0;
      rst_n = 1'b0;
      step();
      chk("rst_ok",   32'(bus.SENHA_OK), 32'd0);
      chk("rst_err",  32'(bus.SENHA_ERRADA), 32'd0);
      chk("rst_blq",  32'(bus.BLOQUEADO), 32'd0);
      chk("rst_qtd",  32'(bus.QTD_DIGITOS), 32'd0);
      rst_n = 1'b1;
      step();

      // correct entry
      bus.HABILITA = 1'b1;
      step();
      enter_1234();
      chk("ok_qtd4", 32'(bus.QTD_DIGITOS), 32'd4);
      confirm();
      chk("ok_verif_lat", 32'(bus.SENHA_OK), 32'd0);
      step();
      chk("ok_accept", 32'(bus.SENHA_OK), 32'd1);
      step(); step();
      chk("ok_hold", 32'(bus.SENHA_OK), 32'd1);
      bus.HABILITA = 1'b0;
      step();
      chk("ok_drop", 32'(bus.SENHA_OK), 32'd0);

      // wrong entry then retry
      bus.HABILITA = 1'b1;
      step();
      press(4'd1); press(4'd2); press(4'd3); press(4'd5);
      confirm();
      chk("wr_verif", 32'(bus.SENHA_ERRADA), 32'd0);
      step();
      chk("wr_pulse", 32'(bus.SENHA_ERRADA), 32'd1);
      chk("wr_qtd0", 32'(bus.QTD_DIGITOS), 32'd0);
      step();
      chk("wr_pulse_end", 32'(bus.SENHA_ERRADA), 32'd0);
      enter_1234();
      confirm();
      step();
      chk("wr_retry_ok", 32'(bus.SENHA_OK), 32'd1);
      bus.HABILITA = 1'b0;
      step();

      // input filtering
      bus.HABILITA = 1'b1;
      step();
      press(4'd1); press(4'd2); press(4'hA);
      chk("flt_hex_ignored", 32'(bus.QTD_DIGITOS), 32'd2);
      bus.LIMPA = 1'b1;
      step();
      bus.LIMPA = 1'b0;
      chk("flt_limpa", 32'(bus.QTD_DIGITOS), 32'd0);
      enter_1234();
      press(4'd7);
      chk("flt_saturate", 32'(bus.QTD_DIGITOS), 32'd4);
      confirm();
      step();
      chk("flt_accept", 32'(bus.SENHA_OK), 32'd1);
      bus.HABILITA = 1'b0;
      step();

      // attempt 1: short entry
      bus.HABILITA = 1'b1;
      step();
      press(4'd1); press(4'd2); press(4'd3);
      confirm();
      step();
      chk("short_reject", 32'(bus.SENHA_ERRADA), 32'd1);
      step();

      // attempt 2: digit strobe coincident with confirm is discarded
      press(4'd1); press(4'd2); press(4'd3);
      bus.DIGITO        = 4'd4;
      bus.DIGITO_VALIDO = 1'b1;
      bus.CONFIRMA      = 1'b1;
      step();
      bus.DIGITO_VALIDO = 1'b0;
      bus.CONFIRMA      = 1'b0;
      step();
      chk("simul_reject", 32'(bus.SENHA_ERRADA), 32'd1);
      step();

      // abort mid-entry keeps attempt count
      press(4'd1); press(4'd2);
      bus.HABILITA = 1'b0;
      step();
      chk("abort_qtd0", 32'(bus.QTD_DIGITOS), 32'd0);
      bus.HABILITA = 1'b1;
      step();
      chk("abort_buf_clr", 32'(bus.QTD_DIGITOS), 32'd0);

      // attempt 3 locks
      press(4'd9); press(4'd9); press(4'd9); press(4'd9);
      confirm();
      step();
      chk("lock_third_err", 32'(bus.SENHA_ERRADA), 32'd1);
      step();
      chk("lock_enter", 32'(bus.BLOQUEADO), 32'd1);
      lock_cycles = 1;
      for (int i = 0; i < 2000; i++) begin
         bus.DIGITO        = 4'(i % 10);
         bus.DIGITO_VALIDO = 1'b1;
         bus.CONFIRMA      = (i % 7 == 3);
         step();
         if (!bus.BLOQUEADO) break;
         lock_cycles++;
      end
      bus.DIGITO_VALIDO = 1'b0;
      bus.CONFIRMA      = 1'b0;
      chk("lock_len", 32'(lock_cycles), 32'd1000);
      chk("lock_exit_qtd", 32'(bus.QTD_DIGITOS), 32'd0);
      chk("lock_exit_ok", 32'(bus.SENHA_OK), 32'd0);
      enter_1234();
      confirm();
      step();
      chk("lock_after_ok", 32'(bus.SENHA_OK), 32'd1);
      bus.HABILITA = 1'b0;
      step();

      // reset in the middle of a lockout
      bus.HABILITA = 1'b1;
      step();
      for (int k = 0; k < 3; k++) begin
         confirm();
         step();
         step();
      end
      chk("rst_lock_in", 32'(bus.BLOQUEADO), 32'd1);
      repeat (10) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_blq", 32'(bus.BLOQUEADO), 32'd0);
      chk("rst_async_qtd", 32'(bus.QTD_DIGITOS), 32'd0);
      #2;
      rst_n = 1'b1;
      step();
      enter_1234();
      chk("rst_fresh_qtd", 32'(bus.QTD_DIGITOS), 32'd4);
      confirm();
      step();
      chk("rst_fresh_ok", 32'(bus.SENHA_OK), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
